// File: rtl/branch_target_predictor.sv
// ---------------------------------------------------------------------------
// branch_target_predictor
//
// Branch target buffer with per-entry tags and 2-bit saturating direction
// counters, backed by an in-flight queue of outstanding predictions.
// Fetch/decode issues lookups and gets a combinational direction/target
// prediction. Execute resolves jumps in program order. Each resolution is
// checked against the oldest queued prediction. A wrong prediction raises
// a registered mispredict pulse with the correct next PC and flushes the
// queue.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   lookup_valid        lookup request this cycle
//   lookup_is_jump      looked-up instruction is a jump/branch
//   lookup_pc           PC of the looked-up instruction
//   lookup_ready        queue can accept a jump lookup (not full)
//   pred_taken          predicted taken (combinational)
//   pred_target         predicted target (combinational)
//   resolve_valid       oldest outstanding jump resolved this cycle
//   resolve_taken       actual direction
//   resolve_target      actual target (meaningful when taken)
//   mispredict          registered one-cycle mispredict pulse
//   redirect_pc         registered correct next PC, valid with mispredict
//   mispredict_count    saturating mispredict counter
// ---------------------------------------------------------------------------
module branch_target_predictor #(
    parameter int ADDR_W  = 16,
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 4,
    parameter int QDEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic              lookup_is_jump,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              lookup_ready,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic [ADDR_W-1:0] resolve_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [CNT_W-1:0] QDEPTH_CNT = CNT_W'(QDEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              taken;
        logic [ADDR_W-1:0] target;
    } q_entry_t;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic              tbl_valid_q  [ENTRIES];
    logic [1:0]        tbl_ctr_q    [ENTRIES];
    logic [TAG_W-1:0]  tbl_tag_q    [ENTRIES];
    logic [ADDR_W-1:0] tbl_target_q [ENTRIES];

    q_entry_t          q_mem_q [QDEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              mispredict_q, mispredict_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [15:0]       mis_count_q, mis_count_d;

    // -----------------------------------------------------------------------
    // Lookup / prediction (combinational, reads pre-update table contents)
    // -----------------------------------------------------------------------
    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic               push;

    assign lk_idx       = lookup_pc[INDEX_W-1:0];
    assign lk_tag       = lookup_pc[INDEX_W+TAG_W-1:INDEX_W];
    assign lk_hit       = tbl_valid_q[lk_idx] && (tbl_tag_q[lk_idx] == lk_tag);
    assign lookup_ready = (count_q != QDEPTH_CNT);
    assign push         = lookup_valid && lookup_is_jump && lookup_ready;

    // Counter values 2 and 3 mean "taken", so bit 1 is the direction.
    assign pred_taken   = push && lk_hit && tbl_ctr_q[lk_idx][1];
    assign pred_target  = tbl_target_q[lk_idx];

    // PC bits above the tag take no part in indexing or tagging.
    generate
        if (INDEX_W + TAG_W < ADDR_W) begin : g_unused_pc
            logic unused_pc_hi;
            assign unused_pc_hi = ^lookup_pc[ADDR_W-1:INDEX_W+TAG_W];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Resolution against the queue head
    // -----------------------------------------------------------------------
    q_entry_t           head;
    logic               pop;
    logic               mis;
    logic [ADDR_W-1:0]  correct_pc;
    logic [INDEX_W-1:0] h_idx;
    logic [TAG_W-1:0]   h_tag;
    logic               h_hit;
    logic [1:0]         h_ctr;

    assign head  = q_mem_q[head_q];
    assign pop   = resolve_valid && (count_q != '0);
    assign h_idx = head.pc[INDEX_W-1:0];
    assign h_tag = head.pc[INDEX_W+TAG_W-1:INDEX_W];
    assign h_hit = tbl_valid_q[h_idx] && (tbl_tag_q[h_idx] == h_tag);
    assign h_ctr = tbl_ctr_q[h_idx];

    assign mis = pop && ((resolve_taken != head.taken) ||
                         (resolve_taken && head.taken && (resolve_target != head.target)));

    assign correct_pc = resolve_taken ? resolve_target : (head.pc + ADDR_W'(1));

    // -----------------------------------------------------------------------
    // Table update request
    // -----------------------------------------------------------------------
    logic       upd_meta_we;  // writes valid + ctr
    logic       upd_data_we;  // writes tag + target
    logic [1:0] upd_ctr;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        upd_meta_we = 1'b0;
        upd_data_we = 1'b0;
        upd_ctr     = h_ctr;
        if (pop) begin
            if (resolve_taken) begin
                // Hit strengthens toward taken; miss allocates weakly taken,
                // evicting whatever aliased entry lived at this index.
                upd_meta_we = 1'b1;
                upd_data_we = 1'b1;
                if (h_hit) begin
                    upd_ctr = (h_ctr == 2'd3) ? 2'd3 : h_ctr + 2'd1;
                end else begin
                    upd_ctr = 2'd2;
                end
            end else if (h_hit) begin
                upd_meta_we = 1'b1;
                upd_ctr     = (h_ctr == 2'd0) ? 2'd0 : h_ctr - 2'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid_q[i] <= 1'b0;
                tbl_ctr_q[i]   <= 2'd0;
            end
        end else if (upd_meta_we) begin
            tbl_valid_q[h_idx] <= 1'b1;
            tbl_ctr_q[h_idx]   <= upd_ctr;
        end
    end

    // NOTE: tag/target and queue payload are plain storage with no reset;
    // the reset valid bits and queue count keep stale contents invisible.
    always_ff @(posedge clk) begin
        if (upd_data_we) begin
            tbl_tag_q[h_idx]    <= h_tag;
            tbl_target_q[h_idx] <= resolve_target;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem_q[tail_q] <= '{pc: lookup_pc, taken: pred_taken, target: pred_target};
        end
    end

    // -----------------------------------------------------------------------
    // Queue pointers, mispredict outputs, statistics
    // -----------------------------------------------------------------------
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        mispredict_d  = mis;
        redirect_pc_d = redirect_pc_q;
        mis_count_d   = mis_count_q;

        if (mis) begin
            // Everything younger than the head is wrong-path work, including
            // a push requested this very cycle.
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            redirect_pc_d = correct_pc;
            if (mis_count_q != 16'hFFFF) begin
                mis_count_d = mis_count_q + 16'd1;
            end
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            mis_count_q   <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            mis_count_q   <= mis_count_d;
        end
    end

    assign mispredict       = mispredict_q;
    assign redirect_pc      = redirect_pc_q;
    assign mispredict_count = mis_count_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_target_predictor
//
// Directed bench for branch_target_predictor. Predictions are checked
// combinationally within the lookup cycle; every clocked cycle pushes the
// expected {mispredict, redirect_pc} onto a scoreboard that is popped and
// compared right after the edge that registers them.
// ---------------------------------------------------------------------------
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_valid;
    logic        lookup_is_jump;
    logic [15:0] lookup_pc;
    logic        lookup_ready;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [15:0] resolve_target;
    logic        mispredict;
    logic [15:0] redirect_pc;
    logic [15:0] mispredict_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        mis;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];

    branch_target_predictor #(
        .ADDR_W (16),
        .INDEX_W(8),
        .TAG_W  (4),
        .QDEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .lookup_valid    (lookup_valid),
        .lookup_is_jump  (lookup_is_jump),
        .lookup_pc       (lookup_pc),
        .lookup_ready    (lookup_ready),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .resolve_valid   (resolve_valid),
        .resolve_taken   (resolve_taken),
        .resolve_target  (resolve_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        lookup_valid   = 1'b0;
        lookup_is_jump = 1'b0;
        lookup_pc      = 16'h0;
        resolve_valid  = 1'b0;
        resolve_taken  = 1'b0;
        resolve_target = 16'h0;
    endtask

    // Present a jump lookup and check the combinational prediction.
    // The lookup stays driven; follow with cyc() to push it or drop() not to.
    task automatic pred(input logic [15:0] pc, input logic exp_taken,
                        input logic [15:0] exp_tgt, input string tag);
        lookup_valid   = 1'b1;
        lookup_is_jump = 1'b1;
        lookup_pc      = pc;
        #1;
        check({tag, ".pred_taken"}, pred_taken, exp_taken);
        if (exp_taken) check({tag, ".pred_target"}, pred_target, exp_tgt);
    endtask

    task automatic drop();
        lookup_valid   = 1'b0;
        lookup_is_jump = 1'b0;
    endtask

    // One clock cycle with optional resolve; scoreboard the registered result.
    task automatic cyc(input logic rv, input logic rt, input logic [15:0] rtg,
                       input logic exp_mis, input logic [15:0] exp_pc, input string tag);
        exp_t e;
        resolve_valid  = rv;
        resolve_taken  = rt;
        resolve_target = rtg;
        sb.push_back('{mis: exp_mis, pc: exp_pc});
        @(posedge clk);
        #1;
        clear_inputs();
        e = sb.pop_front();
        check({tag, ".mispredict"}, mispredict, e.mis);
        if (e.mis) check({tag, ".redirect_pc"}, redirect_pc, e.pc);
    endtask

    initial begin
        int exp_cnt;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst.lookup_ready", lookup_ready, 1'b1);
        check("rst.mispredict", mispredict, 1'b0);
        check("rst.redirect_pc", redirect_pc, 16'h0);
        check("rst.count", mispredict_count, 16'h0);

        // Cold miss then allocate (ctr=2, target 0x40)
        pred(16'h0010, 1'b0, 16'h0, "cold");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "cold.push");
        cyc(1'b1, 1'b1, 16'h0040, 1'b1, 16'h0040, "cold.res");
        pred(16'h0010, 1'b1, 16'h0040, "cold.hit");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "cold.pulse");
        cyc(1'b1, 1'b1, 16'h0040, 1'b0, 16'h0, "train3");

        // Hysteresis: ctr 3 -> 2 still taken -> 1 not taken
        pred(16'h0010, 1'b1, 16'h0040, "hys1");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "hys1.push");
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0011, "hys1.res");
        pred(16'h0010, 1'b1, 16'h0040, "hys2");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "hys2.push");
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0011, "hys2.res");
        pred(16'h0010, 1'b0, 16'h0, "hys3");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "hys3.push");

        // Read-before-write: lookup during the update still sees ctr=1;
        // its push is flushed by the mispredict.
        pred(16'h0010, 1'b0, 16'h0, "rbw.old");
        cyc(1'b1, 1'b1, 16'h0040, 1'b1, 16'h0040, "rbw.res");
        check("rbw.ready", lookup_ready, 1'b1);
        pred(16'h0010, 1'b1, 16'h0040, "rbw.new");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "rbw.push");
        cyc(1'b1, 1'b1, 16'h0040, 1'b0, 16'h0, "rbw.flushchk");

        // Target change at ctr=3
        pred(16'h0010, 1'b1, 16'h0040, "tgt");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "tgt.push");
        cyc(1'b1, 1'b1, 16'h0080, 1'b1, 16'h0080, "tgt.res");
        pred(16'h0010, 1'b1, 16'h0080, "tgt.new");
        drop();

        // Tag alias: 0x0110 evicts 0x0010
        pred(16'h0110, 1'b0, 16'h0, "alias");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "alias.push");
        cyc(1'b1, 1'b1, 16'h0200, 1'b1, 16'h0200, "alias.res");
        pred(16'h0010, 1'b0, 16'h0, "alias.old");
        pred(16'h0110, 1'b1, 16'h0200, "alias.new");
        drop();

        // Not taken on a miss leaves the table alone
        pred(16'h0020, 1'b0, 16'h0, "ntmiss");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "ntmiss.push");
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, "ntmiss.res");
        pred(16'h0020, 1'b0, 16'h0, "ntmiss.after");
        drop();

        // Simultaneous push+pop, non-jump, fill, hold while full, flush
        pred(16'h0040, 1'b0, 16'h0, "q40");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "q40.push");
        pred(16'h0041, 1'b0, 16'h0, "q41");
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, "q41.pushpop");
        pred(16'h0042, 1'b0, 16'h0, "q42");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "q42.push");
        pred(16'h0043, 1'b0, 16'h0, "q43");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "q43.push");
        check("q3.ready", lookup_ready, 1'b1);
        lookup_valid = 1'b1;
        lookup_is_jump = 1'b0;
        lookup_pc = 16'h0050;
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "nonjump");
        check("nonjump.ready", lookup_ready, 1'b1);
        pred(16'h0044, 1'b0, 16'h0, "q44");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "q44.push");
        check("full.ready", lookup_ready, 1'b0);
        pred(16'h0110, 1'b0, 16'h0, "full.hitgated");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "full.hold");
        check("full.ready2", lookup_ready, 1'b0);
        cyc(1'b1, 1'b1, 16'h00A0, 1'b1, 16'h00A0, "full.flush");
        check("flush.ready", lookup_ready, 1'b1);
        pred(16'h0041, 1'b1, 16'h00A0, "order.head41");
        pred(16'h0040, 1'b0, 16'h0, "order.popped40");
        drop();

        // Resolve on empty queue: no mispredict, no table change
        cyc(1'b1, 1'b1, 16'h0099, 1'b0, 16'h0, "empty.res");
        pred(16'h0041, 1'b1, 16'h00A0, "empty.t41");
        pred(16'h0042, 1'b0, 16'h0, "empty.t42");
        pred(16'h0043, 1'b0, 16'h0, "empty.t43");
        pred(16'h0044, 1'b0, 16'h0, "empty.t44");
        pred(16'h0110, 1'b1, 16'h0200, "empty.t110");
        drop();
        check("count.seven", mispredict_count, 16'd7);

        // Saturation: preload near the top, then 5 more mispredicts
        dut.mis_count_q = 16'hFFFC;
        for (int i = 0; i < 5; i++) begin
            lookup_valid = 1'b1;
            lookup_is_jump = 1'b1;
            lookup_pc = 16'h0060;
            cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "sat.push");
            cyc(1'b1, 1'b1, 16'h0070 + 16'(i), 1'b1, 16'h0070 + 16'(i), "sat.res");
            exp_cnt = 32'hFFFC + i + 1;
            if (exp_cnt > 32'hFFFF) exp_cnt = 32'hFFFF;
            check("sat.count", mispredict_count, exp_cnt);
        end

        // Reset mid-queue with a resolve pending
        lookup_valid = 1'b1;
        lookup_is_jump = 1'b1;
        lookup_pc = 16'h0010;
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "mid.push1");
        lookup_valid = 1'b1;
        lookup_is_jump = 1'b1;
        lookup_pc = 16'h0011;
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "mid.push2");
        check("mid.notready_pre", lookup_ready, 1'b1);
        reset = 1'b1;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        resolve_target = 16'h0500;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        check("mid.mispredict", mispredict, 1'b0);
        check("mid.redirect_pc", redirect_pc, 16'h0);
        check("mid.count", mispredict_count, 16'h0);
        check("mid.ready", lookup_ready, 1'b1);
        pred(16'h0110, 1'b0, 16'h0, "mid.inv110");
        pred(16'h0060, 1'b0, 16'h0, "mid.inv60");
        drop();
        cyc(1'b1, 1'b1, 16'h0033, 1'b0, 16'h0, "mid.emptyres");
        check("mid.count2", mispredict_count, 16'h0);
        check("sb.drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch target buffer with per-entry tags, 2-bit saturating direction counters, and an in-flight prediction queue. It sits between fetch/decode, which issues lookups, and the execute/memory stage, which resolves jumps. It supplies a predicted direction and target per jump instruction. It checks each resolution against the oldest outstanding prediction and issues a registered mispredict/redirect with queue flush.

## Interface
- ADDR_W, 16, PC/target width
- INDEX_W, 8, table index bits; 2**INDEX_W entries, index = lookup_pc[INDEX_W-1:0]
- TAG_W, 4, tag bits = lookup_pc[INDEX_W+TAG_W-1:INDEX_W]; INDEX_W+TAG_W <= ADDR_W
- QDEPTH, 4, in-flight prediction queue depth (power of two, >=2)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- lookup_valid  in  1  lookup request this cycle
- lookup_is_jump  in  1  instruction is a jump/branch
- lookup_pc  in  ADDR_W  PC of the looked-up instruction
- lookup_ready  out  1  queue can accept a jump lookup (= !full)
- pred_taken  out  1  predicted taken (combinational)
- pred_target  out  ADDR_W  predicted target (combinational, valid when pred_taken)
- resolve_valid  in  1  oldest outstanding jump resolved
- resolve_taken  in  1  actual direction
- resolve_target  in  ADDR_W  actual target (meaningful when taken)
- mispredict  out  1  registered one-cycle pulse
- redirect_pc  out  ADDR_W  registered correct next PC, valid with mispredict
- mispredict_count  out  16  saturating count of mispredicts

## Operation
- Entry = {valid, tag, target, ctr[1:0]}. Hit = valid & tag match. pred_taken = lookup_valid & lookup_is_jump & lookup_ready & hit & ctr>=2; otherwise 0. pred_target = entry target regardless.
- Push: lookup_valid & lookup_is_jump & lookup_ready pushes {pc, pred_taken, pred_target}. Non-jumps never push. Lookups with lookup_ready=0 are not pushed; fetch must hold.
- Pop: resolve_valid with queue non-empty pops head H. resolve_valid on an empty queue is ignored: no table update, no mispredict.
- Mispredict when resolve_taken != H.taken, or both taken and resolve_target != H.target.
- Correct next PC = resolve_taken ? resolve_target : H.pc+1 (mod 2**ADDR_W).
- Table update on pop, at H.pc's index/tag:
  - taken & hit: ctr = min(ctr+1, 3); target = resolve_target.
  - taken & miss: allocate valid=1, tag, target = resolve_target, ctr=2; replaces any occupant.
  - not taken & hit: ctr = max(ctr-1, 0).
  - not taken & miss: no change.
- Mispredict flushes the whole queue at the same edge, including a push requested that cycle; the younger entries are wrong-path work.
- mispredict_count increments per mispredict and saturates at 0xFFFF.

## Timing
- Prediction is zero-latency combinational from lookup_pc.
- Table and queue update at the clk edge ending the resolve cycle.
- mispredict/redirect_pc are valid the cycle after resolve_valid, for exactly one cycle.
- Read-before-write: a lookup in the same cycle as an update to the same index sees old contents. The next cycle sees new contents.
- Simultaneous push+pop without mispredict: both occur; occupancy is unchanged. When full, lookup_ready stays 0 that cycle; there is no pass-through.
- Reset (any cycle, including mid-operation): all valid bits 0, ctrs 0, queue empty, lookup_ready=1, pred_taken=0, mispredict=0, redirect_pc=0, mispredict_count=0. Targets and tags may be left unreset.
- Queue pointers wrap modulo QDEPTH. Full/empty use a (log2 QDEPTH + 1)-bit occupancy count.

## Test plan
- Cold miss: after reset, jump pc=0x0010, resolve taken to 0x0040. Expected: pred_taken=0; mispredict=1 next cycle; redirect_pc=0x0040; entry ctr=2. Second lookup of 0x0010 gives pred_taken=1, pred_target=0x0040.
- Counter hysteresis: train 0x0010 to ctr=3, then resolve not-taken once. Expected: redirect_pc=0x0011; next lookup still predicts taken (ctr=2). A second not-taken gives pred_taken=0.
- Target change: with ctr=3, resolve taken to 0x0080. Expected: mispredict with redirect_pc=0x0080; next prediction target is 0x0080.
- Tag alias: train 0x0010, then resolve taken for 0x0110 (same index, different tag). Expected: 0x0110 allocated; lookup of 0x0010 now misses and gives pred_taken=0.
- Queue full/flush: push QDEPTH jumps with no resolve. Expected: lookup_ready=0. Then resolve the head as a mispredict: queue empties and lookup_ready=1 next cycle. A resolve_valid on the empty queue gives no mispredict and no table change.
- Stats and reset: force 0xFFFF+2 mispredicts; count holds at 0xFFFF. Assert reset mid-queue; all outputs return to their reset values next cycle.
